mips_alu_regfile: RTL and testbench
===================================

# mips_alu_regfile

Execute-and-operand datapath block for the 5-stage MIPS pipeline. It contains the 32×32-bit general-purpose register file and the 3-bit-opcode integer ALU. The decode stage drives the two read ports and the writeback stage drives the write port. The execute stage supplies ALU operands, opcode and shift amount, and samples the result and zero flag.

## Interface
- No parameters; data width is fixed at 32 bits and the register count at 32.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all registers.
- rs_addr  input  5  read-port 1 address (instruction[25:21]).
- rt_addr  input  5  read-port 2 address (instruction[20:16]).
- wr_addr  input  5  write address (writeback destination register).
- wr_data  input  32  write data (memory data or ALU result, selected upstream).
- reg_write  input  1  write enable.
- read_data1  output  32  contents of rs_addr.
- read_data2  output  32  contents of rt_addr.
- alu_a  input  32  ALU operand A (rs value).
- alu_b  input  32  ALU operand B (rt value or sign-extended immediate, selected upstream).
- alu_op  input  3  operation select.
- shamt  input  5  shift amount (instruction[10:6]).
- alu_out  output  32  ALU result.
- zero  output  1  1 when alu_out == 0.

## Operation
- Register file:
  - 32 registers of 32 bits.
  - Register 0 always reads as 0; writes to it are discarded.
  - Write: on a rising clk edge with reg_write=1 and wr_addr≠0, reg[wr_addr] ← wr_data.
  - Reads are combinational from rs_addr and rt_addr.
  - Write-through bypass: if reg_write=1, wr_addr≠0 and wr_addr equals a read address, that read port returns wr_data in the same cycle. This lets a writeback and a decode of the same register in one cycle see the new value.
- ALU: purely combinational, evaluated by alu_op:
  - 0 ADD: a+b, modulo 2^32, no overflow detection.
  - 1 SUB: a−b, modulo 2^32.
  - 2 AND: a&b.
  - 3 OR: a|b.
  - 4 SLL: b << shamt, zero fill.
  - 5 SRL: b >> shamt, logical, zero fill.
  - 6: reserved; alu_out = 0, which forces zero = 1.
  - 7 SLT: signed compare, 32'd1 if $signed(a) < $signed(b), else 0.
- Shifts use shamt only; alu_a is ignored for ops 4 and 5.
- zero = (alu_out == 32'd0) for every op.
- clk does not affect the ALU.

## Timing
- Reset:
  - A rising edge with reset=1 clears all 32 registers to 0 and takes priority over a simultaneous write, which is dropped.
  - After that edge, read_data1 and read_data2 are 0 for every address.
  - Reset does not directly drive alu_out or zero; they follow their inputs.
- Write latency: 1 edge into storage. Because of the bypass, the written value is visible on the read ports combinationally in the same cycle the write is presented.
- Read latency: 0 cycles, combinational from the address inputs.
- Simultaneous events:
  - Same-register read and write: the read returns the new data through the bypass.
  - wr_addr=0 with reg_write=1: no state change, and no bypass applies.
- ALU latency: 0 cycles. Inputs must settle before the execute stage captures results; the ALU path is a single combinational stage.
- No handshake; the block has no internal state machine.

## Test plan
- Reset, then read all 32 addresses → every read returns 0; the write presented during the reset edge was not stored.
- Write reg 5 = 100 (reg_write=1), then set rs_addr=5 and rt_addr=5 → both ports return 100 on the following cycle. Write reg 0 = 0xFFFFFFFF → reads of reg 0 still return 0.
- Bypass: with reg_write=1, wr_addr=9, wr_data=0x1234 and rs_addr=9 in the same cycle → read_data1=0x1234 before the edge, and it stays 0x1234 after the edge.
- Arithmetic ops:
  - ADD 7 + 0xFFFFFFFD → 4, zero=0.
  - SUB 5−5 → 0, zero=1.
  - ADD 0xFFFFFFFF+1 → 0, zero=1 (wrap).
- Logic and compare ops:
  - AND 0xF0F0 & 0xFF00 → 0xF000.
  - OR 0xF0F0 | 0x0F0F → 0xFFFF.
  - SLT a=0xFFFFFFFF, b=1 → 1.
  - SLT a=1, b=0xFFFFFFFF → 0.
- Shifts and reserved op:
  - SLL b=1, shamt=4 → 16.
  - SRL b=0x80000000, shamt=31 → 1.
  - SRL with shamt=0 → b unchanged.
  - alu_op=6 → 0, zero=1.

Source files
------------

// File: rtl/mips_alu_regfile.sv
// Operand/execute datapath for a 5-stage MIPS pipeline: 32x32 register file
// with write-through bypass, plus the combinational 3-bit-opcode integer ALU.
module mips_alu_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        reg_write,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [2:0]  alu_op,
  input  logic [4:0]  shamt,
  output logic [31:0] alu_out,
  output logic        zero
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLL = 3'd4;
  localparam logic [2:0] OP_SRL = 3'd5;
  localparam logic [2:0] OP_RSV = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  logic [31:0] regs [32];
  logic        wr_en;

  // A write to r0 is not a write at all: it neither updates storage nor bypasses.
  assign wr_en = reg_write && (wr_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  function automatic logic [31:0] read_port(
    input logic [4:0]  addr,
    input logic [31:0] stored,
    input logic        bypass_en,
    input logic [4:0]  bypass_addr,
    input logic [31:0] bypass_data
  );
    logic [31:0] r;
    r = stored;
    if (addr == 5'd0) begin
      r = 32'd0;
    end else if (bypass_en && (bypass_addr == addr)) begin
      r = bypass_data;
    end
    return r;
  endfunction

  always_comb begin
    read_data1 = read_port(rs_addr, regs[rs_addr], wr_en, wr_addr, wr_data);
    read_data2 = read_port(rt_addr, regs[rt_addr], wr_en, wr_addr, wr_data);
  end

  function automatic logic [31:0] alu_eval(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  sh
  );
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        r;
    sa = a;
    sb = b;
    r  = 32'd0;
    case (op)
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_SLL: r = b << sh;
      OP_SRL: r = b >> sh;
      OP_RSV: r = 32'd0;
      OP_SLT: r = {31'd0, (sa < sb)};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    alu_out = alu_eval(alu_op, alu_a, alu_b, shamt);
    zero    = (alu_out == 32'd0);
  end

endmodule

// File: tb/tb_mips_alu_regfile.sv
// Self-checking bench for mips_alu_regfile: directed cases plus randomized
// register/ALU traffic compared against an array-and-arithmetic reference model.
module tb_mips_alu_regfile;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        reg_write;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [4:0]  shamt;
  logic [31:0] alu_out;
  logic        zero;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [32];

  mips_alu_regfile dut (
    .clk(clk), .reset(reset),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .wr_addr(wr_addr), .wr_data(wr_data), .reg_write(reg_write),
    .read_data1(read_data1), .read_data2(read_data2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .shamt(shamt),
    .alu_out(alu_out), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference ALU from the arithmetic definitions, using 64-bit integers.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    longint unsigned ua, ub, m, p;
    int sa, sb;
    ua = longint'(a);
    ub = longint'(b);
    m  = 64'h1_0000_0000;
    p  = 64'd1 << sh;
    sa = a;
    sb = b;
    case (op)
      3'd0: return 32'((ua + ub) % m);
      3'd1: return 32'((ua + m - ub) % m);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return 32'((ub * p) % m);
      3'd5: return 32'(ub / p);
      3'd6: return 32'd0;
      default: return (sa < sb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] ra, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (ra == 0) return 32'd0;
    if (we && wa != 0 && wa == ra) return wd;
    return model[ra];
  endfunction

  task automatic alu_case(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] exp, input logic exp_zero);
    alu_op = op; alu_a = a; alu_b = b; shamt = sh;
    #1;
    check({tag, "_out"}, alu_out, exp);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
  endtask

  initial begin
    logic        we;
    logic [4:0]  wa, ra1, ra2;
    logic [31:0] wd, r;

    reset = 1'b0; reg_write = 1'b0; wr_addr = '0; wr_data = '0;
    rs_addr = '0; rt_addr = '0;
    alu_a = '0; alu_b = '0; alu_op = '0; shamt = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    // Reset with a competing write that must be dropped.
    #2;
    reset = 1'b1; reg_write = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0; reg_write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      #1;
      check("rst_rd1", read_data1, 32'd0);
      check("rst_rd2", read_data2, 32'd0);
    end

    // Plain write then read.
    reg_write = 1'b1; wr_addr = 5'd5; wr_data = 32'd100;
    tick();
    model[5] = 32'd100;
    reg_write = 1'b0; rs_addr = 5'd5; rt_addr = 5'd5;
    #1;
    check("wr5_rd1", read_data1, 32'd100);
    check("wr5_rd2", read_data2, 32'd100);

    // Writes to r0 are discarded and never bypass.
    reg_write = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    check("r0_nobypass", read_data1, 32'd0);
    tick();
    reg_write = 1'b0;
    #1;
    check("r0_rd1", read_data1, 32'd0);
    check("r0_rd2", read_data2, 32'd0);

    // Same-cycle write-through bypass.
    reg_write = 1'b1; wr_addr = 5'd9; wr_data = 32'h1234; rs_addr = 5'd9; rt_addr = 5'd5;
    #1;
    check("byp_before", read_data1, 32'h1234);
    check("byp_other", read_data2, 32'd100);
    tick();
    model[9] = 32'h1234;
    reg_write = 1'b0;
    #1;
    check("byp_after", read_data1, 32'h1234);

    // Directed ALU cases.
    alu_case("add_neg",  3'd0, 32'd7, 32'hFFFF_FFFD, 5'd0, 32'd4, 1'b0);
    alu_case("sub_eq",   3'd1, 32'd5, 32'd5, 5'd0, 32'd0, 1'b1);
    alu_case("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b1);
    alu_case("and",      3'd2, 32'hF0F0, 32'hFF00, 5'd0, 32'hF000, 1'b0);
    alu_case("or",       3'd3, 32'hF0F0, 32'h0F0F, 5'd0, 32'hFFFF, 1'b0);
    alu_case("slt_neg",  3'd7, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0);
    alu_case("slt_pos",  3'd7, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1);
    alu_case("sll",      3'd4, 32'hAAAA_AAAA, 32'd1, 5'd4, 32'd16, 1'b0);
    alu_case("srl31",    3'd5, 32'hFFFF_FFFF, 32'h8000_0000, 5'd31, 32'd1, 1'b0);
    alu_case("srl0",     3'd5, 32'd0, 32'hCAFE_F00D, 5'd0, 32'hCAFE_F00D, 1'b0);
    alu_case("rsv",      3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 32'd0, 1'b1);

    // Randomized register-file and ALU traffic against the model.
    for (int n = 0; n < 400; n++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = 5'($urandom_range(0, 31));
      reg_write = we; wr_addr = wa; wr_data = wd; rs_addr = ra1; rt_addr = ra2;
      alu_op = 3'($urandom_range(0, 7));
      alu_a  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      alu_b  = ($urandom_range(0, 7) == 0) ? alu_a : $urandom;
      shamt  = 5'($urandom_range(0, 31));
      #1;
      check("rnd_rd1", read_data1, ref_read(ra1, we, wa, wd));
      check("rnd_rd2", read_data2, ref_read(ra2, we, wa, wd));
      r = ref_alu(alu_op, alu_a, alu_b, shamt);
      check("rnd_alu", alu_out, r);
      check("rnd_zero", {31'd0, zero}, {31'd0, (r == 32'd0)});
      tick();
      if (we && wa != 0) model[wa] = wd;
    end

    // Second reset after traffic clears everything again.
    reset = 1'b1; reg_write = 1'b1; wr_addr = 5'd7; wr_data = 32'h5555_AAAA;
    tick();
    reset = 1'b0; reg_write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      model[i] = 32'd0;
      rs_addr = 5'(i); rt_addr = 5'(i);
      #1;
      check("rst2_rd1", read_data1, model[i]);
      check("rst2_rd2", read_data2, model[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
